// File: rtl/array_lane_sram_ext.sv
// array_lane_sram_ext
//   Parametrised single-port SRAM model with these features:
//   - lane-masked writes
//   - a self-clearing init sweep after reset
//   - a qualified read pipeline (RD_LATENCY = 1 or 2)
//   Each lane is its own RAM array, so a masked write only touches the enabled lanes.
//   Optional feature macro: ARRAY_PARITY_EN adds one even-parity bit per lane, with an
//   inject-on-write flip and per-lane error flags on read.
//   The port list is the same whether or not the macro is defined.
module array_lane_sram_ext #(
    parameter int                DEPTH      = 1024,
    parameter int                ADDR_W     = 10,
    parameter int                LANES      = 10,
    parameter int                LANE_W     = 18,
    parameter int                RD_LATENCY = 1,
    parameter logic [LANE_W-1:0] INIT_VALUE = '0
) (
    input  logic                     RW0_clk,
    input  logic                     RW0_rst_n,
    input  logic                     RW0_en,
    input  logic                     RW0_wmode,
    input  logic [ADDR_W-1:0]        RW0_addr,
    input  logic [LANES-1:0]         RW0_wmask,
    input  logic [LANES*LANE_W-1:0]  RW0_wdata,
    input  logic [LANES-1:0]         RW0_pinj,
    output logic                     RW0_ready,
    output logic                     RW0_rvalid,
    output logic [LANES*LANE_W-1:0]  RW0_rdata,
    output logic [LANES-1:0]         RW0_perr
);

    localparam int DATA_W = LANES * LANE_W;
`ifdef ARRAY_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int STORE_W = LANE_W + PAR_BITS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic                ready_reg;

    logic                init_active;
    logic                wr_acc;
    logic                rd_acc;
    logic [ADDR_W-1:0]   wr_addr;

    logic                s1_valid_reg;
    logic [DATA_W-1:0]   s1_data;
    logic [LANES-1:0]    s1_perr;

    assign init_active = (state_reg == ST_INIT);
    assign wr_acc      = RW0_en & ready_reg & RW0_wmode;
    assign rd_acc      = RW0_en & ready_reg & ~RW0_wmode;
    assign wr_addr     = init_active ? ptr_reg : RW0_addr;
    assign RW0_ready   = ready_reg;

    // Init sweep FSM: one word per cycle, then RUN with ready held high until reset
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_reg <= ST_INIT;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    ptr_reg <= ptr_reg + 1'b1;
                    if (ptr_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                        ptr_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // First read stage valid: set on the edge that accepts a read, lost on reset
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_acc;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [STORE_W-1:0] mem [DEPTH];
            logic [LANE_W-1:0]  lane_wdata;
            logic [STORE_W-1:0] wr_word;
            logic               wr_en;
            logic [STORE_W-1:0] rd_word_reg;

            assign lane_wdata = init_active ? INIT_VALUE : RW0_wdata[gi*LANE_W +: LANE_W];
            assign wr_en      = init_active | (wr_acc & RW0_wmask[gi]);
`ifdef ARRAY_PARITY_EN
            // Even parity; the inject flip only applies to user writes (sweep is always clean)
            assign wr_word = {(^lane_wdata) ^ (~init_active & RW0_pinj[gi]), lane_wdata};
            assign s1_perr[gi] = ^rd_word_reg;
`else
            assign wr_word = lane_wdata;
            assign s1_perr[gi] = 1'b0;
`endif

            // Lane RAM write port, shared by the init sweep and masked user writes
            always_ff @(posedge RW0_clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_word;
                end
            end

            // Registered read, loaded only on accepted reads so the result holds between reads
            always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
                if (!RW0_rst_n) begin
                    rd_word_reg <= '0;
                end else if (rd_acc) begin
                    rd_word_reg <= mem[RW0_addr];
                end
            end

            assign s1_data[gi*LANE_W +: LANE_W] = rd_word_reg[LANE_W-1:0];
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic              out_valid_reg;
            logic [DATA_W-1:0] out_data_reg;
            logic [LANES-1:0]  out_perr_reg;

            // Output stage: data/perr load only when the first stage carries a valid read
            always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
                if (!RW0_rst_n) begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                    out_perr_reg  <= '0;
                end else begin
                    out_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        out_data_reg <= s1_data;
                        out_perr_reg <= s1_perr;
                    end
                end
            end

            assign RW0_rvalid = out_valid_reg;
            assign RW0_rdata  = out_data_reg;
            assign RW0_perr   = out_perr_reg;
        end else begin : g_lat1
            assign RW0_rvalid = s1_valid_reg;
            assign RW0_rdata  = s1_data;
            assign RW0_perr   = s1_perr;
        end
    endgenerate

`ifndef ARRAY_PARITY_EN
    // Inject input has no effect without parity storage
    logic unused_pinj;
    assign unused_pinj = ^RW0_pinj;
`endif

endmodule

// File: tb/tb_array_lane_sram_ext.sv
// Directed bench for array_lane_sram_ext.
// Two instances share one stimulus stream:
//   - instance a uses read latency 1
//   - instance b uses read latency 2
module tb_array_lane_sram_ext;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         wmode;
    logic [9:0]   addr;
    logic [9:0]   wmask;
    logic [179:0] wdata;
    logic [9:0]   pinj;

    logic         a_ready, a_rvalid, b_ready, b_rvalid;
    logic [179:0] a_rdata, b_rdata;
    logic [9:0]   a_perr, b_perr;

    int checks = 0;
    int errors = 0;

    logic [179:0] ones;
    logic [179:0] pat_a;
    logic [179:0] pat_b;
    logic [179:0] pat_p;
    logic [179:0] exp7;
    logic [9:0]   exp_perr;
    int           n;

    always #5 clk = ~clk;

    array_lane_sram_ext #(.RD_LATENCY(1)) dut_a (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_pinj(pinj),
        .RW0_ready(a_ready), .RW0_rvalid(a_rvalid), .RW0_rdata(a_rdata), .RW0_perr(a_perr)
    );

    array_lane_sram_ext #(.RD_LATENCY(2)) dut_b (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_pinj(pinj),
        .RW0_ready(b_ready), .RW0_rvalid(b_rvalid), .RW0_rdata(b_rdata), .RW0_perr(b_perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [179:0] obs, input logic [179:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0; pinj = '0;
    endtask

    task automatic set_write(input logic [9:0] a, input logic [9:0] m,
                             input logic [179:0] d, input logic [9:0] p);
        en = 1'b1; wmode = 1'b1; addr = a; wmask = m; wdata = d; pinj = p;
    endtask

    task automatic set_read(input logic [9:0] a);
        en = 1'b1; wmode = 1'b0; addr = a; wmask = '0; wdata = '0; pinj = '0;
    endtask

    initial begin
        ones  = '1;
        pat_a = '0;
        pat_b = '0;
        pat_p = '0;
        for (int i = 0; i < 10; i++) begin
            pat_a[i*18 +: 18] = 18'h01000 + 18'(i);
            pat_b[i*18 +: 18] = 18'h20000 + 18'(i * 16);
            pat_p[i*18 +: 18] = 18'h15555;
        end
        exp7 = '0;
        exp7[17:0] = 18'h12345;
`ifdef ARRAY_PARITY_EN
        exp_perr = 10'h004;
`else
        exp_perr = 10'h000;
`endif

        // Reset state
        idle();
        rst_n = 1'b0;
        tick(); tick();
        check("rst_ready_a",  180'(a_ready),  180'(0));
        check("rst_rvalid_a", 180'(a_rvalid), 180'(0));
        check("rst_rdata_a",  a_rdata,        180'(0));
        check("rst_perr_a",   180'(a_perr),   180'(0));
        check("rst_ready_b",  180'(b_ready),  180'(0));
        check("rst_rdata_b",  b_rdata,        180'(0));

        // Init sweep length: ready rises on the 1024th edge after release
        rst_n = 1'b1;
        n = 0;
        while (a_ready !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        check("init_cycles", 180'(n), 180'(1024));
        check("init_ready_b", 180'(b_ready), 180'(1));

        // Read addr 5 after init: rvalid latency 1 (a) and 2 (b), data 0
        set_read(10'd5);
        tick();
        idle();
        check("rd5_rvalid_a", 180'(a_rvalid), 180'(1));
        check("rd5_rdata_a",  a_rdata,        180'(0));
        check("rd5_rvalid_b0", 180'(b_rvalid), 180'(0));
        tick();
        check("rd5_pulse_a",  180'(a_rvalid), 180'(0));
        check("rd5_rvalid_b", 180'(b_rvalid), 180'(1));

        // Full write to addr 3, then read it on the very next cycle
        set_write(10'd3, 10'h3FF, ones, 10'h000);
        tick();
        check("wr3_no_rvalid", 180'(a_rvalid), 180'(0));
        set_read(10'd3);
        tick();
        idle();
        check("raw3_rvalid_a", 180'(a_rvalid), 180'(1));
        check("raw3_rdata_a",  a_rdata,        ones);
        tick();
        check("raw3_pulse_a",  180'(a_rvalid), 180'(0));
        check("raw3_hold_a",   a_rdata,        ones);
        check("raw3_rvalid_b", 180'(b_rvalid), 180'(1));
        check("raw3_rdata_b",  b_rdata,        ones);

        // wmask=0 must not change addr 3
        set_write(10'd3, 10'h000, 180'(0), 10'h000);
        tick();
        set_read(10'd3);
        tick();
        idle();
        check("nomask_rdata_a", a_rdata, ones);

        // Single-lane write to addr 7; other lanes of wdata are all ones and must be ignored
        set_write(10'd7, 10'h001, {{162{1'b1}}, 18'h12345}, 10'h000);
        tick();
        set_read(10'd7);
        tick();
        idle();
        check("lane0_rdata_a", a_rdata, exp7);

        // Back-to-back reads of addr 1 and 2 are returned in order on both latencies
        set_write(10'd1, 10'h3FF, pat_a, 10'h000);
        tick();
        set_write(10'd2, 10'h3FF, pat_b, 10'h000);
        tick();
        set_read(10'd1);
        tick();
        check("pipe_a_first",  a_rdata,        pat_a);
        check("pipe_b_idle",   180'(b_rvalid), 180'(0));
        set_read(10'd2);
        tick();
        idle();
        check("pipe_a_second", a_rdata,        pat_b);
        check("pipe_a_valid2", 180'(a_rvalid), 180'(1));
        check("pipe_b_first",  b_rdata,        pat_a);
        check("pipe_b_valid1", 180'(b_rvalid), 180'(1));
        tick();
        check("pipe_b_second", b_rdata,        pat_b);
        check("pipe_b_valid2", 180'(b_rvalid), 180'(1));
        check("pipe_a_done",   180'(a_rvalid), 180'(0));
        tick();
        check("pipe_b_done",   180'(b_rvalid), 180'(0));
        check("pipe_b_hold",   b_rdata,        pat_b);

        // Parity inject on lane 2 of addr 9
        set_write(10'd9, 10'h3FF, pat_p, 10'h004);
        tick();
        set_read(10'd9);
        tick();
        idle();
        check("par_perr_a",  180'(a_perr), 180'(exp_perr));
        check("par_rdata_a", a_rdata,      pat_p);
        tick();
        check("par_perr_b",  180'(b_perr), 180'(exp_perr));

        // Async reset with a read still in flight in the latency-2 pipe
        set_read(10'd3);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready_b",  180'(b_ready),  180'(0));
        check("arst_rvalid_b", 180'(b_rvalid), 180'(0));
        check("arst_rvalid_a", 180'(a_rvalid), 180'(0));
        tick();
        tick();
        check("arst_nolate_b", 180'(b_rvalid), 180'(0));

        // Requests during the sweep are dropped; sweep restarts and clears addr 3
        rst_n = 1'b1;
        set_read(10'd3);
        n = 0;
        while (a_ready !== 1'b1 && n < 1100) begin
            tick();
            n++;
            if (n == 3) begin
                check("drop_rvalid_a", 180'(a_rvalid), 180'(0));
                idle();
            end
        end
        check("reinit_cycles", 180'(n), 180'(1024));
        set_read(10'd3);
        tick();
        idle();
        check("reinit_rvalid_a", 180'(a_rvalid), 180'(1));
        check("reinit_rdata_a",  a_rdata,        180'(0));
        tick();
        check("reinit_rdata_b",  b_rdata,        180'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
